// File: rtl/miriscv_arb_pkg.sv
// Shared types and default widths for the miriscv memory arbiter.
// Owner tags travel through the response FIFO; lock states drive selection.
package miriscv_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_I    = 2'd1,
        LK_D    = 2'd2
    } lock_t;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_MAX_OUTST  = 2;
    localparam int ARB_STARVE_LIM = 4;

endpackage

// File: rtl/miriscv_owner_fifo.sv
// Circular FIFO of owner tags for accepted-but-unanswered memory requests.
// Full/empty come from the registered count only.
module miriscv_owner_fifo
    import miriscv_arb_pkg::*;
#(
    parameter int DEPTH = ARB_MAX_OUTST
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   push_i,
    input  owner_t push_owner_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    owner_t        slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_i) begin
                slots[wr_ptr] <= push_owner_i;
                wr_ptr        <= nxt(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (push_i && !pop_i) begin
                cnt <= cnt + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign full_o  = (cnt == CW'(DEPTH));
    assign empty_o = (cnt == '0);
    assign head_o  = slots[rd_ptr];

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares the single memory port between instruction fetch (I) and LSU (D).
// Lock FSM keeps the chosen request stable until the memory grants it.
module miriscv_mem_arbiter
    import miriscv_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MAX_OUTST  = ARB_MAX_OUTST,
    parameter int STARVE_LIM = ARB_STARVE_LIM
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    lock_t         lock_q;
    lock_t         lock_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    owner_t        sel;
    owner_t        head;
    logic          req_sel;
    logic          accept;
    logic          full;
    logic          empty;
    logic          pop;
    logic          sel_d;

    always_comb begin
        sel    = OWN_I;
        lock_d = lock_q;
        unique case (lock_q)
            LK_I: sel = OWN_I;
            LK_D: sel = OWN_D;
            default: begin
                if (starve_q == SW'(STARVE_LIM)) begin
                    sel = OWN_I;
                end else if (data_req_i) begin
                    sel = OWN_D;
                end else begin
                    sel = OWN_I;
                end
            end
        endcase

        sel_d   = (sel == OWN_D);
        req_sel = sel_d ? data_req_i : instr_req_i;
        // Outstanding limit uses the registered count; a same-cycle pop does not help.
        mem_req_o = rst_n_i & req_sel & ~full;
        accept    = mem_req_o & mem_gnt_i;

        if (lock_q == LK_NONE) begin
            if (req_sel && !accept) begin
                lock_d = sel_d ? LK_D : LK_I;
            end
        end else if (accept) begin
            lock_d = LK_NONE;
        end

        starve_d = starve_q;
        if (!instr_req_i || (accept && !sel_d)) begin
            starve_d = '0;
        end else if (accept && sel_d && starve_q != SW'(STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock_q   <= LK_NONE;
            starve_q <= '0;
            err_o    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            starve_q <= starve_d;
            if (mem_rvalid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end

    miriscv_owner_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (accept),
        .push_owner_i(sel),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    assign mem_we_o    = mem_req_o & sel_d & data_we_i;
    assign mem_be_o    = !mem_req_o ? '0 : (sel_d ? data_be_i : '1);
    assign mem_addr_o  = !mem_req_o ? '0 : (sel_d ? data_addr_i : instr_addr_i);
    assign mem_wdata_o = (mem_req_o && sel_d) ? data_wdata_i : '0;

    assign instr_gnt_o = accept & ~sel_d;
    assign data_gnt_o  = accept & sel_d;

    assign pop            = rst_n_i & mem_rvalid_i & ~empty;
    assign instr_rvalid_o = pop & (head == OWN_I);
    assign data_rvalid_o  = pop & (head == OWN_D);
    assign instr_rdata_o  = rst_n_i ? mem_rdata_i : '0;
    assign data_rdata_o   = rst_n_i ? mem_rdata_i : '0;

endmodule
